avalon_mm_csr_slave: RTL
========================

Name: avalon_mm_csr_slave

Overview:
- Avalon-MM slave endpoint that terminates the team's avalon_mm_bus and backs it with a bank of 32-bit control/status registers.
- Sits directly downstream of the bus master.
- Supports single and burst reads/writes, waitrequest back-pressure, pipelined read data and write responses.
- Register contents are exported as a flat vector to the LLRF datapath.

Parameters:
- DEPTH, 16: number of 32-bit registers; legal 2..256, power of two.
- RO_MASK, 16'h0000: bit i set makes register i read-only. Writes to it are dropped and report SLAVEERROR.
- MAX_BURST, 16: largest burstcount accepted. Larger values get an error response.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- address  in  16  word address (one address = one 32-bit word)
- byteenable  in  4  byte lanes for writes; ignored on reads
- read  in  1  read request
- write  in  1  write request
- writedata  in  32  write data
- burstcount  in  11  beats in the burst; 0 is treated as 1
- beginbursttransfer  in  1  first-cycle marker; informational only, not required
- waitrequest  out  1  slave not ready
- readdata  out  32  read data
- readdatavalid  out  1  readdata qualifier
- response  out  2  00 OKAY, 10 SLAVEERROR
- writeresponsevalid  out  1  write response qualifier
- regs_out  out  DEPTH*32  register contents; register i is at bits [32*i+31:32*i]
- status_in  in  DEPTH*32  value returned by reads of read-only registers

Behaviour:
- **Reset** (reset_n low at a clock edge):
  - state = IDLE, all registers = 0.
  - waitrequest = 0, readdatavalid = 0, writeresponsevalid = 0, readdata = 0, response = 00.
  - Reset mid-burst aborts the burst immediately; no further beats or responses are issued.
- **Acceptance**:
  - A command is accepted in IDLE when read or write is high and waitrequest is low.
  - read and write high together: write wins; read is ignored for that cycle.
- **States**:
  - IDLE: on write, latch base address and beat count (burstcount, 0 becomes 1), process beat 0, go to WR_BURST. If the count is 1, go straight to WR_RESP. On read, latch address and count, go to RD_BURST.
  - WR_BURST: waitrequest = 0. Each cycle with write high consumes one beat at address base+k. Cycles with write low are idle (master stall) and k holds. After the last beat, go to WR_RESP.
  - WR_RESP: writeresponsevalid = 1 for exactly one cycle, then IDLE. response = 10 if any beat of the burst errored, else 00. waitrequest = 1 in this state.
  - RD_BURST: waitrequest = 1 for the whole burst. One beat per cycle, with readdatavalid registered one cycle after the beat index is issued. Return to IDLE after the final readdatavalid. waitrequest drops in the same cycle as the final readdatavalid.
- **Latency**:
  - Write response: 1 cycle after the last accepted data beat.
  - First read data: 1 cycle after acceptance; beats are back-to-back with no gaps.
- **Write beat**:
  - Index i = address[7:0] + k, with no wrap.
  - If i < DEPTH and RO_MASK[i] = 0: update each byte lane j of register i where byteenable[j] = 1. Update is visible on regs_out the next cycle.
  - Otherwise the beat is dropped and the burst is flagged as an error.
- **Read beat**:
  - i < DEPTH: readdata = RO_MASK[i] ? status_in word i : register i; response 00.
  - Otherwise readdata = 32'hDEAD_BEEF, response 10, per beat.
  - Any address with bits [15:8] nonzero is out of range.
- **Error conditions**:
  - burstcount > MAX_BURST: the burst is still fully transferred (all beats consumed or returned) but every beat is errored. No register is modified and reads return DEADBEEF.
  - A burst crossing DEPTH: in-range beats complete normally; out-of-range beats error.
- **Timing**: all outputs are registered; no combinational path from inputs to waitrequest.

Test Plan:
1. Single write of 32'h1234_5678 to address 3, byteenable 4'hF -> writeresponsevalid pulse 1 cycle after the beat, response 00, regs_out word 3 = 32'h1234_5678. A read of address 3 then returns that value 1 cycle after acceptance.
2. Byte-enable write of 32'hAABB_CCDD to address 3 with byteenable 4'b0101 over the value from test 1 -> register 3 = 32'h12BB_56DD.
3. Write burst of 4 beats at address 2 with data 1,2,3,4 and the master deasserting write for 2 cycles between beats 2 and 3 -> registers 2..5 = 1..4 and a single response 00 after beat 4. Then a 4-beat read burst from address 2 -> 4 consecutive readdatavalid cycles returning 1,2,3,4, with waitrequest high throughout and dropping with the last beat.
4. RO_MASK = 16'h0002, status_in word 1 = 32'hCAFE_0001. Write to address 1 -> response 10, regs_out word 1 stays 0. Read of address 1 -> 32'hCAFE_0001, response 00.
5. Read burst of 3 beats at address 15 with DEPTH = 16 -> beat 0 returns register 15 with response 00; beats 1 and 2 return 32'hDEAD_BEEF with response 10. A write with burstcount = 17 -> all 17 beats consumed, response 10, no register changes.
6. Assert reset_n low during beat 2 of a 4-beat read burst -> the next cycle shows readdatavalid = 0, waitrequest = 0 and all registers 0. A new single read after reset completes normally.

Source files
------------

// File: rtl/avalon_mm_csr_slave.sv
// Avalon-MM slave exposing a bank of 32-bit control/status registers.
// Handles single and burst transfers with registered outputs and per-burst write responses.
module avalon_mm_csr_slave #(
  parameter int               DEPTH     = 16,
  parameter logic [DEPTH-1:0] RO_MASK   = '0,
  parameter int               MAX_BURST = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [15:0]          address,
  input  logic [3:0]           byteenable,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic [10:0]          burstcount,
  input  logic                 beginbursttransfer,
  output logic                 waitrequest,
  output logic [31:0]          readdata,
  output logic                 readdatavalid,
  output logic [1:0]           response,
  output logic                 writeresponsevalid,
  output logic [DEPTH*32-1:0]  regs_out,
  input  logic [DEPTH*32-1:0]  status_in
);

  localparam int          AW          = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W     = 17'(DEPTH);
  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [31:0] ERR_WORD    = 32'hDEAD_BEEF;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_BURST, WR_RESP, RD_BURST} state_t;

  state_t      state_reg, state_next;
  logic [15:0] base_reg, base_next;
  logic [10:0] cnt_reg, cnt_next;
  logic [10:0] k_reg, k_next;
  logic        err_reg, err_next;
  logic        big_reg, big_next;

  logic        waitrequest_reg, waitrequest_next;
  logic [31:0] readdata_reg, readdata_next;
  logic        readdatavalid_reg, readdatavalid_next;
  logic [1:0]  response_reg, response_next;
  logic        wrespvalid_reg, wrespvalid_next;

  logic [10:0]   eff_count;
  logic          oversize;
  logic [15:0]   cur_base;
  logic [10:0]   cur_k;
  logic          cur_big;
  logic [16:0]   beat_idx;
  logic          in_range;
  logic [AW-1:0] beat_lo;
  logic          beat_ro;
  logic          wr_ok;
  logic          rd_ok;
  logic [31:0]   beat_rdata;
  logic [1:0]    beat_rresp;
  logic          last_beat;
  logic          wr_en;

  logic [31:0] regs_word   [DEPTH];
  logic [31:0] status_word [DEPTH];

  // Marker is informational; the latched burstcount alone delimits a burst.
  logic unused_ok;
  assign unused_ok = beginbursttransfer;

  assign waitrequest        = waitrequest_reg;
  assign readdata           = readdata_reg;
  assign readdatavalid      = readdatavalid_reg;
  assign response           = response_reg;
  assign writeresponsevalid = wrespvalid_reg;

  assign eff_count = (burstcount == 11'd0) ? 11'd1 : burstcount;
  assign oversize  = {21'd0, burstcount} > MAX_BURST_W;
  assign last_beat = (k_reg == (cnt_reg - 11'd1));

  // In IDLE the beat being processed is beat 0 of the incoming command.
  always_comb begin
    if (state_reg == IDLE) begin
      cur_base = address;
      cur_k    = 11'd0;
      cur_big  = oversize;
    end else begin
      cur_base = base_reg;
      cur_k    = k_reg;
      cur_big  = big_reg;
    end
  end

  assign beat_idx   = {1'b0, cur_base} + {6'd0, cur_k};
  assign in_range   = beat_idx < DEPTH_W;
  assign beat_lo    = beat_idx[AW-1:0];
  assign beat_ro    = RO_MASK[beat_lo];
  assign wr_ok      = in_range && !beat_ro && !cur_big;
  assign rd_ok      = in_range && !cur_big;
  assign beat_rdata = !rd_ok ? ERR_WORD : (beat_ro ? status_word[beat_lo] : regs_word[beat_lo]);
  assign beat_rresp = rd_ok ? RESP_OKAY : RESP_SLVERR;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [31:0] word_reg;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        word_reg <= '0;
      end else if (wr_en && (beat_lo == AW'(gi))) begin
        for (int j = 0; j < 4; j++) begin
          if (byteenable[j]) begin
            word_reg[8*j +: 8] <= writedata[8*j +: 8];
          end
        end
      end
    end

    assign regs_word[gi]          = word_reg;
    assign status_word[gi]        = status_in[32*gi +: 32];
    assign regs_out[32*gi +: 32]  = word_reg;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      base_reg          <= '0;
      cnt_reg           <= '0;
      k_reg             <= '0;
      err_reg           <= 1'b0;
      big_reg           <= 1'b0;
      waitrequest_reg   <= 1'b0;
      readdata_reg      <= '0;
      readdatavalid_reg <= 1'b0;
      response_reg      <= RESP_OKAY;
      wrespvalid_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      base_reg          <= base_next;
      cnt_reg           <= cnt_next;
      k_reg             <= k_next;
      err_reg           <= err_next;
      big_reg           <= big_next;
      waitrequest_reg   <= waitrequest_next;
      readdata_reg      <= readdata_next;
      readdatavalid_reg <= readdatavalid_next;
      response_reg      <= response_next;
      wrespvalid_reg    <= wrespvalid_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    base_next          = base_reg;
    cnt_next           = cnt_reg;
    k_next             = k_reg;
    err_next           = err_reg;
    big_next           = big_reg;
    waitrequest_next   = waitrequest_reg;
    readdata_next      = readdata_reg;
    readdatavalid_next = 1'b0;
    response_next      = RESP_OKAY;
    wrespvalid_next    = 1'b0;
    wr_en              = 1'b0;

    case (state_reg)
      IDLE: begin
        // Write takes priority when both strobes are high.
        if (write && !waitrequest_reg) begin
          base_next = address;
          cnt_next  = eff_count;
          big_next  = oversize;
          k_next    = 11'd1;
          wr_en     = wr_ok;
          err_next  = !wr_ok;
          if (eff_count == 11'd1) begin
            state_next       = WR_RESP;
            wrespvalid_next  = 1'b1;
            response_next    = wr_ok ? RESP_OKAY : RESP_SLVERR;
            waitrequest_next = 1'b1;
          end else begin
            state_next = WR_BURST;
          end
        end else if (read && !waitrequest_reg) begin
          base_next          = address;
          cnt_next           = eff_count;
          big_next           = oversize;
          k_next             = 11'd1;
          readdata_next      = beat_rdata;
          response_next      = beat_rresp;
          readdatavalid_next = 1'b1;
          if (eff_count != 11'd1) begin
            state_next       = RD_BURST;
            waitrequest_next = 1'b1;
          end
        end
      end

      WR_BURST: begin
        if (write) begin
          wr_en    = wr_ok;
          err_next = err_reg || !wr_ok;
          k_next   = k_reg + 11'd1;
          if (last_beat) begin
            state_next       = WR_RESP;
            wrespvalid_next  = 1'b1;
            response_next    = (err_reg || !wr_ok) ? RESP_SLVERR : RESP_OKAY;
            waitrequest_next = 1'b1;
          end
        end
      end

      WR_RESP: begin
        state_next       = IDLE;
        waitrequest_next = 1'b0;
      end

      RD_BURST: begin
        readdata_next      = beat_rdata;
        response_next      = beat_rresp;
        readdatavalid_next = 1'b1;
        k_next             = k_reg + 11'd1;
        // waitrequest falls together with the final readdatavalid.
        if (last_beat) begin
          state_next       = IDLE;
          waitrequest_next = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
